if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-002 rst_i  input  1  reset, synchronous and active-low.
REQ-003 start_i  input  1  level; fetching begins on the first edge with start_i=1 after reset.
REQ-004 stall_i  input  1  hazard stall from decode; 1 means the IF/ID register does not capture.
REQ-005 MemStall_i  input  1  data-cache stall; 1 means the IF/ID register does not capture.
REQ-006 flush_i  input  1  branch/jump redirect; the IF/ID register captures a bubble.
REQ-007 flush_pc_i  input  32  redirect target, valid when flush_i=1.
REQ-008 imem_req_o  output  1  instruction-memory request.
REQ-009 imem_addr_o  output  32  request address, word aligned.
REQ-010 imem_ack_i  input  1  one-cycle completion strobe; imem_data_i is valid in the same cycle.
REQ-011 imem_data_i  input  32  fetched instruction word.
REQ-012 instr_o  output  32  instruction to the IF/ID register; 32'b0 means bubble.
REQ-013 PC_o  output  32  address of instr_o.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, REQ (request outstanding), HOLD (instruction buffered), and DROP (outstanding request to be discarded).
REQ-015 A capture by the IF/ID register ("accept") SHALL be defined as state=HOLD and stall_i=0 and MemStall_i=0 and flush_i=0.
REQ-016 IDLE SHALL drive imem_req_o=0 and go to REQ with fetch_pc=0 on start_i=1.
REQ-017 REQ and DROP SHALL drive imem_req_o=1 with imem_addr_o=fetch_pc.
REQ-018 imem_addr_o SHALL stay constant from request assertion until ack.
REQ-019 Ack may arrive in the first cycle of a request.
REQ-020 REQ with imem_ack_i=1 SHALL capture imem_data_i and fetch_pc into the buffer and go to HOLD.
REQ-021 HOLD SHALL drive imem_req_o=0 and drive instr_o/PC_o from the buffer; outside HOLD, instr_o=0 and PC_o=buffered PC.
REQ-022 HOLD on accept SHALL set fetch_pc=fetch_pc+4 and go to REQ.
REQ-023 HOLD without accept SHALL keep instr_o/PC_o stable, whatever the stall duration.
REQ-024 Throughput SHALL be at most one instruction per two cycles (one REQ cycle plus one HOLD cycle minimum).
REQ-025 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 gives 32'h0000_0000.
REQ-026 flush_pc_i[1:0] SHALL be ignored and treated as 2'b00.
REQ-027 flush_i SHALL take precedence over stall_i, MemStall_i and accept in every state.
REQ-028 Flush in IDLE SHALL be ignored.
REQ-029 Flush in HOLD SHALL discard the buffer, set fetch_pc=target and go to REQ.
REQ-030 Flush in REQ with no ack SHALL record target in pending_pc and go to DROP.
REQ-031 Flush in REQ with ack SHALL discard imem_data_i, set fetch_pc=target and go to REQ; the new request is issued the next cycle.
REQ-032 DROP with ack SHALL discard data, set fetch_pc=pending_pc and go to REQ.
REQ-033 DROP with a further flush and no ack SHALL overwrite pending_pc.
REQ-034 A flush coinciding with ack in DROP SHALL use the new target.
REQ-035 A discarded instruction SHALL never appear on instr_o.

Reset
REQ-036 rst_i=0 at any edge SHALL force: state=IDLE, fetch_pc=0, pending_pc=0, buffer=0, imem_req_o=0, instr_o=0, PC_o=0.
REQ-037 Reset mid-transaction SHALL abandon the outstanding request; the instruction memory is reset by the same rst_i.

Structure
REQ-038 A shared cpu_pkg SHALL hold the fetch state enum, RESET_PC=32'h0, PC_STEP=4 and NOP_BUBBLE=32'b0.
REQ-039 The block SHALL be a single FSM plus PC and buffer registers, with no sub-module.

Verification
REQ-040 Reset, start_i=1, ack latency 0: addresses 0,4,8 requested; instr_o nonzero every second cycle; PC_o=0,4,8.
REQ-041 Ack latency 3 cycles: imem_addr_o stable all 3 cycles; instr_o=0 until HOLD.
REQ-042 HOLD at PC=8 with MemStall_i=1 for 5 cycles: instr_o/PC_o unchanged and imem_req_o=0; release leads to request at 12.
REQ-043 Flush to 32'h40 while REQ at 12 pending, ack 2 cycles later with data 32'hDEADBEEF: that word is never output; next request is to 0x40.
REQ-044 Flush to 0x80 then to 0x100 during DROP, then ack: next request is to 0x100; flush_pc_i=0x103 requests 0x100.
REQ-045 Fetch at 32'hFFFF_FFFC accepted: next request is to 0; rst_i=0 mid-REQ gives imem_req_o=0 and instr_o=0 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding and PC constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] NOP_BUBBLE = 32'b0;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/ack bus between the fetch stage and imem.
interface if_fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;

  modport master (output imem_req_o, imem_addr_o, input imem_ack_i, imem_data_i);
  modport slave  (input imem_req_o, imem_addr_o, output imem_ack_i, imem_data_i);
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding imem request, one-entry buffer
// feeding the IF/ID register, with redirect (flush) handling.
module if_fetch
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              MemStall_i,
  input  logic              flush_i,
  input  logic [31:0]       flush_pc_i,
  if_fetch_if.master        imem,
  output logic [31:0]       instr_o,
  output logic [31:0]       PC_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  pending_pc_q, pending_pc_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic [31:0]  target;
  logic         accept;

  assign target = word_align(flush_pc_i);
  assign accept = (state_q == HOLD) && !stall_i && !MemStall_i && !flush_i;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = REQ;
          fetch_pc_d = RESET_PC;
        end
      end
      REQ: begin
        // A redirect wins over a returning word; without ack the request
        // must still be drained, so the target is parked in pending_pc.
        if (flush_i) begin
          if (imem.imem_ack_i) begin
            fetch_pc_d = target;
          end else begin
            pending_pc_d = target;
            state_d      = DROP;
          end
        end else if (imem.imem_ack_i) begin
          buf_instr_d = imem.imem_data_i;
          buf_pc_d    = fetch_pc_q;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (flush_i) begin
          buf_instr_d = NOP_BUBBLE;
          fetch_pc_d  = target;
          state_d     = REQ;
        end else if (accept) begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = REQ;
        end
      end
      DROP: begin
        if (imem.imem_ack_i) begin
          fetch_pc_d = flush_i ? target : pending_pc_q;
          state_d    = REQ;
        end else if (flush_i) begin
          pending_pc_d = target;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      buf_instr_q  <= NOP_BUBBLE;
      buf_pc_q     <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
    end
  end

  assign imem.imem_req_o  = (state_q == REQ) || (state_q == DROP);
  assign imem.imem_addr_o = fetch_pc_q;
  assign instr_o          = (state_q == HOLD) ? buf_instr_q : NOP_BUBBLE;
  assign PC_o             = buf_pc_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus randomized traffic against a
// transaction-level reference model, compared every cycle.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, start, stall, mem_stall, flush;
  logic [31:0] flush_pc;
  logic [31:0] instr, pc;

  if_fetch_if bus ();

  if_fetch dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .stall_i    (stall),
    .MemStall_i (mem_stall),
    .flush_i    (flush),
    .flush_pc_i (flush_pc),
    .imem       (bus),
    .instr_o    (instr),
    .PC_o       (pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  // Instruction memory: latency counted from the first cycle of each request.
  int          lat_fix;
  int          cnt, lat;
  bit          prev_req, prev_ack;
  bit          ovr_en;
  logic [31:0] data_ovr;

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.imem_req_o) begin
      if (!prev_req || prev_ack) begin
        cnt = 0;
        lat = (lat_fix < 0) ? int'($urandom_range(0, 3)) : lat_fix;
      end else begin
        cnt++;
      end
      bus.imem_ack_i = (cnt == lat);
    end else begin
      bus.imem_ack_i = 1'b0;
    end
    bus.imem_data_i = bus.imem_ack_i ? (ovr_en ? data_ovr : word(bus.imem_addr_o)) : $urandom;
    prev_req = bus.imem_req_o;
    prev_ack = bus.imem_ack_i;
  endtask

  // Reference model: is fetching running, is an instruction being presented,
  // is the outstanding word doomed, and which address is in flight.
  logic        m_run, m_have, m_drop;
  logic [31:0] m_addr, m_pend, m_bpc, m_bdata;
  wire  [31:0] tgt = flush_pc & 32'hFFFF_FFFC;

  always @(posedge clk) begin
    if (!rst) begin
      m_run <= 0; m_have <= 0; m_drop <= 0;
      m_addr <= 0; m_pend <= 0; m_bpc <= 0; m_bdata <= 0;
    end else if (!m_run) begin
      if (start) begin
        m_run  <= 1;
        m_addr <= 0;
      end
    end else if (m_have) begin
      if (flush) begin
        m_have <= 0;
        m_addr <= tgt;
      end else if (!stall && !mem_stall) begin
        m_have <= 0;
        m_addr <= m_bpc + 32'd4;
      end
    end else if (!m_drop) begin
      if (bus.imem_ack_i) begin
        if (flush) m_addr <= tgt;
        else begin
          m_have  <= 1;
          m_bpc   <= m_addr;
          m_bdata <= bus.imem_data_i;
        end
      end else if (flush) begin
        m_drop <= 1;
        m_pend <= tgt;
      end
    end else begin
      if (bus.imem_ack_i) begin
        m_drop <= 0;
        m_addr <= flush ? tgt : m_pend;
      end else if (flush) begin
        m_pend <= tgt;
      end
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req", {31'b0, bus.imem_req_o}, {31'b0, m_run && !m_have});
      if (m_run && !m_have) chk("addr", bus.imem_addr_o, m_addr);
      chk("instr", instr, m_have ? m_bdata : 32'b0);
      chk("pc", pc, m_bpc);
    end
  end

  initial begin
    rst = 0; start = 0; stall = 0; mem_stall = 0; flush = 0; flush_pc = 0;
    bus.imem_ack_i = 0; bus.imem_data_i = 0;
    lat_fix = 0; ovr_en = 0; data_ovr = 0; prev_req = 0; prev_ack = 0; cnt = 0; lat = 0;
    step(); step();
    chk_en = 1;
    chk("rst_req", {31'b0, bus.imem_req_o}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc, 32'd0);

    // Zero-latency streaming: 0, 4, 8 one instruction per two cycles.
    rst = 1; start = 1;
    step(); chk("t1_req0", {31'b0, bus.imem_req_o}, 32'd1); chk("t1_addr0", bus.imem_addr_o, 32'h0);
    step(); chk("t1_instr0", instr, 32'hC0DE_0001); chk("t1_pc0", pc, 32'h0);
    step(); chk("t1_addr4", bus.imem_addr_o, 32'h4); chk("t1_bubble", instr, 32'h0);
    step(); chk("t1_pc4", pc, 32'h4);
    step(); chk("t1_addr8", bus.imem_addr_o, 32'h8);
    step(); chk("t1_pc8", pc, 32'h8);

    // Data-cache stall while holding PC 8.
    mem_stall = 1;
    repeat (5) begin
      step();
      chk("stall_instr", instr, word(32'h8));
      chk("stall_pc", pc, 32'h8);
      chk("stall_req", {31'b0, bus.imem_req_o}, 32'd0);
    end

    // Release, then redirect to 0x40 while the request at 12 is pending.
    mem_stall = 0; lat_fix = 2; ovr_en = 1; data_ovr = 32'hDEAD_BEEF;
    step(); chk("rel_addr12", bus.imem_addr_o, 32'hC);
    flush = 1; flush_pc = 32'h40;
    step(); chk("drop_addr12", bus.imem_addr_o, 32'hC); chk("drop_instr", instr, 32'h0);
    flush = 0;
    step(); chk("dead_hidden", instr, 32'h0);
    ovr_en = 0; lat_fix = 3;
    step(); chk("redir_addr40", bus.imem_addr_o, 32'h40); chk("dead_hidden2", instr, 32'h0);
    repeat (3) begin
      step(); chk("lat3_addr", bus.imem_addr_o, 32'h40); chk("lat3_instr", instr, 32'h0);
    end
    step(); chk("lat3_pc", pc, 32'h40); chk("lat3_instr_v", instr, 32'hC0DE_0041);

    // Double redirect during DROP; the latest target wins.
    step(); chk("addr44", bus.imem_addr_o, 32'h44);
    flush = 1; flush_pc = 32'h80;
    step();
    flush_pc = 32'h100;
    step();
    flush = 0;
    step(); chk("drop_addr44", bus.imem_addr_o, 32'h44);
    step(); chk("dbl_addr100", bus.imem_addr_o, 32'h100);

    // Misaligned target gets its low bits cleared.
    flush = 1; flush_pc = 32'h103;
    step(); flush = 0;
    step(); step();
    lat_fix = 0;
    step(); chk("align_addr100", bus.imem_addr_o, 32'h100);

    // Wrap at the top of the address space, then reset mid-request.
    flush = 1; flush_pc = 32'hFFFF_FFFC;
    step(); chk("wrap_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
    flush = 0;
    step(); chk("wrap_pc", pc, 32'hFFFF_FFFC);
    lat_fix = 3;
    step(); chk("wrap_next", bus.imem_addr_o, 32'h0); chk("wrap_req", {31'b0, bus.imem_req_o}, 32'd1);
    rst = 0;
    step();
    chk("mid_rst_req", {31'b0, bus.imem_req_o}, 32'd0);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    rst = 1;

    // Randomized traffic.
    lat_fix = -1;
    repeat (4000) begin
      rst       = ($urandom_range(0, 199) != 0);
      start     = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 3) == 0);
      mem_stall = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 5) == 0);
      flush_pc  = $urandom;
      step();
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
